bus_burst_reader: RTL

BUS_BURST_READER -- requirements
Module: bus_burst_reader

---
 rtl/bus_burst_reader_pkg.sv | 26 ++
 rtl/bus_burst_reader_word_fifo.sv | 81 ++++++++
 rtl/bus_burst_reader.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/bus_burst_reader_pkg.sv
// bus_burst_reader_pkg
//   Shared bus constants for the burst reader and its output buffer:
//   word/address width, the unmapped address driven while no read is
//   issued, default buffer depth, request length encoding and the FSM
//   state codes. Address-range constants live here only.
package bus_burst_reader_pkg;

  localparam int WORD_SIZE  = 16;
  localparam logic [WORD_SIZE-1:0] IDLE_ADDR = 16'h0000;
  localparam int FIFO_DEPTH = 4;

  // Request length field and the one-bit-wider burst word count
  // (a length field of zero means a full 256-word burst).
  localparam int LEN_W   = 8;
  localparam int BURST_W = LEN_W + 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  // Convert the request length field into an actual word count.
  function automatic logic [BURST_W-1:0] burstWords(input logic [LEN_W-1:0] len);
    return (len == '0) ? {1'b1, {LEN_W{1'b0}}} : {1'b0, len};
  endfunction

endpackage

// File: rtl/bus_burst_reader_word_fifo.sv
// word_fifo
//   Synchronous output buffer for returned bus words.
//   Ports:
//     read_clk  - clock, all state on posedge
//     reset     - asynchronous active-high reset, empties the buffer
//     push_i    - write wdata_i this cycle
//     wdata_i   - word to write
//     pop_i     - drop the head word this cycle
//     rdata_o   - head word (held until popped)
//     empty_o   - no words buffered
//     count_o   - number of buffered words
module word_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                         read_clk,
  input  logic                         reset,
  input  logic                         push_i,
  input  logic [WIDTH-1:0]             wdata_i,
  input  logic                         pop_i,
  output logic [WIDTH-1:0]             rdata_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wrPtr_q;
  logic [PTR_W-1:0] rdPtr_q;
  logic [CNT_W-1:0] count_q;
  logic             full;
  logic             doPush;
  logic             doPop;

  function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH-1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rdPtr_q];

  // A push into a full buffer is only legal when the head leaves in the
  // same cycle; otherwise the word is dropped and the assertion fires.
  assign doPop  = pop_i && !empty_o;
  assign doPush = push_i && (!full || doPop);

  // Storage carries no reset; only pointers and count define contents.
  always_ff @(posedge read_clk) begin
    if (doPush) begin
      mem_q[wrPtr_q] <= wdata_i;
    end
  end

  always_ff @(posedge read_clk or posedge reset) begin
    if (reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (doPush) begin
        wrPtr_q <= nextPtr(wrPtr_q);
      end
      if (doPop) begin
        rdPtr_q <= nextPtr(rdPtr_q);
      end
      case ({doPush, doPop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  noOverflow: assert property (@(posedge read_clk) disable iff (reset)
                               !(push_i && full && !pop_i));

endmodule

// File: rtl/bus_burst_reader.sv
// bus_burst_reader
//   Accepts a burst request (start address, length), issues consecutive
//   read addresses on read_bus while buffer credit allows, captures the
//   returned data_bus word one cycle after each issued address, and hands
//   the words to a valid/ready consumer, flagging the final one.
//   Ports:
//     read_clk, reset      - clock and asynchronous active-high reset
//     req_valid/req_ready  - request handshake; req_addr, req_len (0=256)
//     read_bus             - issued read address (IDLE_ADDR when none)
//     data_bus             - sampled read data from the responder
//     out_valid/out_ready  - output handshake; out_data, out_last
//     busy                 - burst in progress
//     done                 - one-cycle pulse after the final word is taken
module bus_burst_reader
  import bus_burst_reader_pkg::*;
#(
  parameter int WORD_SIZE  = bus_burst_reader_pkg::WORD_SIZE,
  parameter int FIFO_DEPTH = bus_burst_reader_pkg::FIFO_DEPTH,
  parameter logic [WORD_SIZE-1:0] IDLE_ADDR = bus_burst_reader_pkg::IDLE_ADDR
) (
  input  logic                 reset,
  input  logic                 read_clk,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [WORD_SIZE-1:0] req_addr,
  input  logic [LEN_W-1:0]     req_len,
  output logic [WORD_SIZE-1:0] read_bus,
  input  logic [WORD_SIZE-1:0] data_bus,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WORD_SIZE-1:0] out_data,
  output logic                 out_last,
  output logic                 busy,
  output logic                 done
);

  localparam int CNT_W = $clog2(FIFO_DEPTH+1);
  localparam logic [CNT_W:0] DEPTH_L = (CNT_W+1)'(FIFO_DEPTH);

  logic [1:0]           state_q,     state_d;
  logic [WORD_SIZE-1:0] addr_q,      addr_d;
  logic [BURST_W-1:0]   issueLeft_q, issueLeft_d;
  logic [BURST_W-1:0]   burstLen_q,  burstLen_d;
  logic [BURST_W-1:0]   popCnt_q,    popCnt_d;
  logic                 done_q,      done_d;
  logic                 inflight_q;

  logic [CNT_W-1:0]     fifoCount;
  logic                 fifoEmpty;
  logic [CNT_W:0]       occupancy;
  logic                 credit;
  logic                 accept;
  logic                 issue;
  logic                 pop;

  // Credit counts words already buffered plus the one whose data is still
  // on its way back, so every issued address is guaranteed a buffer slot.
  assign occupancy = {1'b0, fifoCount} + {{CNT_W{1'b0}}, inflight_q};
  assign credit    = (occupancy < DEPTH_L);

  assign accept    = (state_q == ST_IDLE) && req_valid;
  assign issue     = (state_q == ST_ISSUE) && credit;
  assign read_bus  = issue ? addr_q : IDLE_ADDR;

  assign req_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;

  assign out_valid = !fifoEmpty;
  assign pop       = out_valid && out_ready;
  // The head word's ordinal within the burst is one more than the number
  // of words already handed out.
  assign out_last  = out_valid && ((popCnt_q + BURST_W'(1)) == burstLen_q);

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    issueLeft_d = issueLeft_q;
    burstLen_d  = burstLen_q;
    popCnt_d    = pop ? popCnt_q + BURST_W'(1) : popCnt_q;
    done_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          addr_d      = req_addr;
          issueLeft_d = burstWords(req_len);
          burstLen_d  = burstWords(req_len);
          popCnt_d    = '0;
          state_d     = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (issue) begin
          addr_d      = addr_q + WORD_SIZE'(1);
          issueLeft_d = issueLeft_q - BURST_W'(1);
          if (issueLeft_q == BURST_W'(1)) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        // The final word is always captured after the last issue, so its
        // handshake can only ever happen here.
        if (pop && out_last) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge read_clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      issueLeft_q <= '0;
      burstLen_q  <= '0;
      popCnt_q    <= '0;
      done_q      <= 1'b0;
      inflight_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      issueLeft_q <= issueLeft_d;
      burstLen_q  <= burstLen_d;
      popCnt_q    <= popCnt_d;
      done_q      <= done_d;
      inflight_q  <= issue;
    end
  end

  // The responder samples read_bus on one edge and presents data before
  // the next; inflight_q marks exactly those cycles worth capturing.
  word_fifo #(
    .WIDTH (WORD_SIZE),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .read_clk (read_clk),
    .reset    (reset),
    .push_i   (inflight_q),
    .wdata_i  (data_bus),
    .pop_i    (pop),
    .rdata_o  (out_data),
    .empty_o  (fifoEmpty),
    .count_o  (fifoCount)
  );

endmodule
